uart_mmio: RTL and testbench

Memory-mapped 8N1 UART peripheral serving the MEM stage of the pipelined CPU on the 0x4000_0018–0x4000_0020 window. It takes the MEM-stage bus (MemRead, MemWrite, Address, Write_data) and serialises bytes onto `uart_tx`. It deserialises `uart_rx` into a receive holding register and returns data and status combinationally on `Read_data`, in the same cycle, for the MEM-stage result mux.

---
 rtl/uart_mmio.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART for the CPU MEM stage.
// Registers (byte addresses):
//   0x4000_0018 TXD  write starts a frame when idle; read returns last accepted byte
//   0x4000_001C RXD  read returns received byte and clears rx_valid
//   0x4000_0020 CON  read {frame_err, overrun, tx_busy, rx_valid, 0} in bits 4..0;
//                    write bit3 clears overrun, bit4 clears frame_err
// Ports:
//   clk, rst (async active-low)
//   MemRead, MemWrite, Address, Write_data : MEM-stage bus, already decoded
//   Read_data : combinational load data (0 when no read or undecoded)
//   uart_rx   : asynchronous serial input
//   uart_tx   : registered serial output
module uart_mmio #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BIT_HALF = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  // TX state
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_q, tx_d;

  // RX state
  logic        rx_sync1_q, rx_sync2_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;

  logic        byte_latch;
  logic        frame_set;

  logic        sel_txd, sel_rxd, sel_con;
  logic        wr_txd, rd_rxd, wr_con;
  logic        tx_busy;
  logic        unused_wdata;

  assign sel_txd = (Address == ADDR_TXD);
  assign sel_rxd = (Address == ADDR_RXD);
  assign sel_con = (Address == ADDR_CON);
  assign wr_txd  = MemWrite & sel_txd;
  assign rd_rxd  = MemRead & sel_rxd;
  assign wr_con  = MemWrite & sel_con;
  assign tx_busy = (tx_state_q != T_IDLE);
  assign uart_tx = tx_q;
  assign unused_wdata = ^Write_data[31:8];

  // Transmit FSM; a TXD write is only honoured in T_IDLE, so a write in the
  // final stop cycle is dropped because the state is still T_STOP.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    txd_d      = txd_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      T_IDLE: begin
        tx_d = 1'b1;
        if (wr_txd) begin
          txd_d      = Write_data[7:0];
          tx_d       = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_d       = txd_q[0];
          tx_state_d = T_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = T_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            tx_d     = txd_q[tx_idx_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      T_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = T_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  // Receive FSM; samples are taken at mid-bit, aligned by the half-bit wait
  // in R_START, then every full bit period thereafter.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    byte_latch = 1'b0;
    frame_set  = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        if (!rx_sync2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        if (rx_cnt_q == BIT_HALF) begin
          rx_cnt_d = '0;
          if (rx_sync2_q) begin
            rx_state_d = R_IDLE;
          end else begin
            rx_idx_d   = '0;
            rx_state_d = R_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) begin
            rx_state_d = R_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          if (rx_sync2_q) begin
            byte_latch = 1'b1;
          end else begin
            frame_set = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Status flags: a flag set always overrides a same-cycle clear, and a new
  // byte overrides a same-cycle RXD read (which then counts as an overrun).
  always_comb begin
    rx_byte_d   = byte_latch ? rx_shift_q : rx_byte_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (rd_rxd) rx_valid_d = 1'b0;
    if (byte_latch) rx_valid_d = 1'b1;
    if (wr_con && Write_data[3]) overrun_d = 1'b0;
    if (byte_latch && rx_valid_q) overrun_d = 1'b1;
    if (wr_con && Write_data[4]) frame_err_d = 1'b0;
    if (frame_set) frame_err_d = 1'b1;
  end

  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (sel_txd) begin
        Read_data = {24'b0, txd_q};
      end else if (sel_rxd) begin
        Read_data = {24'b0, rx_byte_q};
      end else if (sel_con) begin
        Read_data = {27'b0, frame_err_q, overrun_q, tx_busy, rx_valid_q, 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q  <= T_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      txd_q       <= '0;
      tx_q        <= 1'b1;
      rx_sync1_q  <= 1'b1;
      rx_sync2_q  <= 1'b1;
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      txd_q       <= txd_d;
      tx_q        <= tx_d;
      rx_sync1_q  <= uart_rx;
      rx_sync2_q  <= rx_sync1_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio with CLKS_PER_BIT=16.
// Bus reads push their expected value; a negedge monitor pops and compares.
// A serial monitor decodes uart_tx frames and compares against queued bytes.
module tb_uart_mmio;

  localparam int unsigned CPB = 16;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] Address, Write_data, Read_data;
  logic        uart_rx, uart_tx;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  tx_exp[$];

  logic [31:0] mon_exp;
  string       mon_name;

  uart_mmio #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .Write_data(Write_data),
    .Read_data (Read_data),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus cycle, called and returning at posedge+1.
  task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp, input string name);
    MemRead    = rd;
    MemWrite   = wr;
    Address    = addr;
    Write_data = wd;
    if (rd) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clk);
    #1;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop_bit;
    idle(CPB);
    uart_rx = 1'b1;
  endtask

  // Read scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b1 && MemRead === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read_unexpected got=0x%08h expected=none", Read_data);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, Read_data, mon_exp);
      end
    end
  end

  // Serial TX monitor: samples start, 8 data and stop at bit centres.
  initial begin : tx_mon
    logic [9:0] bits;
    logic       aborted;
    logic [7:0] eb;
    bits    = '0;
    aborted = 1'b0;
    eb      = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && uart_tx === 1'b0) begin
        aborted = 1'b0;
        for (int i = 0; i < 10; i++) begin
          repeat ((i == 0) ? CPB / 2 : CPB) begin
            @(negedge clk);
            if (rst !== 1'b1) aborted = 1'b1;
          end
          bits[i] = uart_tx;
        end
        if (!aborted) begin
          if (tx_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected_frame got=0x%03h expected=none", bits);
          end else begin
            eb = tx_exp.pop_front();
            check("tx_frame", {22'b0, bits}, {22'b0, 1'b1, eb, 1'b0});
          end
        end
      end
    end
  end

  initial begin
    rst        = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
    uart_rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
    rst = 1'b1;
    idle(2);
    bus(1'b1, 1'b0, A_CON, '0, 32'h0, "reset_con");
    bus(1'b1, 1'b0, A_RXD, '0, 32'h0, "reset_rxd");

    // TX 0xA5 with busy window and readback
    tx_exp.push_back(8'hA5);
    bus(1'b0, 1'b1, A_TXD, 32'h0000_01A5, '0, "");
    for (int i = 0; i < 165; i++)
      bus(1'b1, 1'b0, A_CON, '0, (i < 160) ? 32'h4 : 32'h0, "tx_busy_window");
    bus(1'b1, 1'b0, A_TXD, '0, 32'hA5, "txd_readback");
    idle(10);

    // Write while busy is dropped
    tx_exp.push_back(8'h3C);
    bus(1'b0, 1'b1, A_TXD, 32'h3C, '0, "");
    idle(49);
    bus(1'b0, 1'b1, A_TXD, 32'h77, '0, "");
    idle(150);
    bus(1'b1, 1'b0, A_TXD, '0, 32'h3C, "txd_busy_drop");
    idle(20);

    // RX 0x5A, then read clears rx_valid
    send_rx(8'h5A, 1'b1);
    idle(4);
    bus(1'b1, 1'b0, A_CON, '0, 32'h2, "rx_con_valid");
    bus(1'b1, 1'b0, A_RXD, '0, 32'h5A, "rx_data_5a");
    bus(1'b1, 1'b0, A_CON, '0, 32'h0, "rx_con_cleared");

    // Overrun, flag clear, framing error
    send_rx(8'h11, 1'b1);
    idle(4);
    send_rx(8'h22, 1'b1);
    idle(4);
    bus(1'b1, 1'b0, A_CON, '0, 32'hA, "con_overrun");
    bus(1'b0, 1'b1, A_CON, 32'h8, '0, "");
    bus(1'b1, 1'b0, A_CON, '0, 32'h2, "con_overrun_cleared");
    bus(1'b1, 1'b0, A_RXD, '0, 32'h22, "rxd_after_overrun");
    bus(1'b1, 1'b0, A_CON, '0, 32'h0, "con_after_rxd_read");
    send_rx(8'h33, 1'b0);
    idle(4);
    bus(1'b1, 1'b0, A_CON, '0, 32'h10, "con_frame_err");
    bus(1'b1, 1'b0, A_RXD, '0, 32'h22, "rxd_kept_on_frame_err");
    bus(1'b1, 1'b1, A_CON, 32'h10, 32'h10, "rd_wr_same_cycle");
    bus(1'b1, 1'b0, A_CON, '0, 32'h0, "con_frame_err_cleared");

    // Start-bit glitch
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(30);
    bus(1'b1, 1'b0, A_CON, '0, 32'h0, "glitch_no_flags");
    bus(1'b1, 1'b0, A_RXD, '0, 32'h22, "glitch_rxd_kept");

    // Async reset mid-frame (0x55: bit1=0 spans cycles 32..47)
    bus(1'b0, 1'b1, A_TXD, 32'h55, '0, "");
    idle(39);
    check("tx_before_reset", {31'b0, uart_tx}, 32'h0);
    rst = 1'b0;
    #1;
    check("tx_during_reset", {31'b0, uart_tx}, 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    bus(1'b1, 1'b0, A_CON, '0, 32'h0, "con_after_reset");
    bus(1'b1, 1'b0, A_TXD, '0, 32'h0, "txd_after_reset");
    idle(200);

    check("read_queue_drained", 32'(exp_q.size()), 32'h0);
    check("tx_queue_drained", 32'(tx_exp.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
